// File: rtl/output_wbuf.sv
// Write-combining output buffer: merges byte writes into 512 B windows held in two
// ping-pong banks and drains each closed bank as one 64-beat, 64-bit strobed burst.
module output_wbuf (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        we,
    input  logic [23:0] adr,
    input  logic [7:0]  dw,
    output logic        rdy,
    output logic        idle,
    output logic        wreq,
    input  logic        wack,
    output logic [23:0] wadr,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb
);
    localparam int NTFR = 64;
    localparam int NB   = $clog2(NTFR * 8);
    localparam int BW   = $clog2(NTFR);
    localparam int TW   = 24 - NB;

    typedef enum logic [1:0] {B_FREE, B_OPEN, B_CLOSED, B_DRAIN} bst_t;
    typedef enum logic [1:0] {D_IDLE, D_WAITACK, D_BURST} dst_t;

    logic [63:0]   mem  [2][NTFR];
    logic [7:0]    mask [2][NTFR];
    bst_t          st   [2];
    logic [TW-1:0] tag  [2];
    logic [1:0]    has;
    logic          wb, db;
    dst_t          dstate, dnext;
    logic [BW-1:0] beat;
    logic [63:0]   wdata_p1;
    logic [7:0]    wstrb_p1;

    logic          open_v, hit, nb, nb_free, acc, wbank, close_now, flush_empty_close;
    logic          drain_start, drain_done, rd_go, wb_nxt;
    logic [BW-1:0] rd_idx;

    // The Open bank, if any, is always bank wb; a new window opens in wb or its partner.
    always_comb begin
        open_v      = (st[wb] == B_OPEN);
        hit         = open_v && (tag[wb] == adr[23:NB]);
        nb          = open_v ? ~wb : wb;
        drain_done  = (dstate == D_BURST) && wack && (beat == BW'(NTFR - 1));
        nb_free     = (st[nb] == B_FREE) || (drain_done && (db == nb));
        rdy         = !(we && !hit && !nb_free);
        acc         = we && rdy;
        wbank       = hit ? wb : nb;
        close_now   = acc && ((adr[NB-1:0] == '1) || flush);
        flush_empty_close = flush && !acc && open_v && has[wb];
        wb_nxt      = wb ^ (acc && !hit && open_v) ^ close_now ^ flush_empty_close;
        drain_start = (dstate == D_IDLE) && (st[db] == B_CLOSED);
        rd_go       = drain_start ||
                      (wack && ((dstate == D_WAITACK) || ((dstate == D_BURST) && !drain_done)));
        rd_idx      = drain_start ? '0 : beat + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) dstate <= D_IDLE;
        else     dstate <= dnext;
    end

    always_comb begin
        dnext = dstate;
        case (dstate)
            D_IDLE:    if (st[db] == B_CLOSED) dnext = D_WAITACK;
            D_WAITACK: if (wack) dnext = D_BURST;
            D_BURST:   if (drain_done) dnext = D_IDLE;
            default:   dnext = D_IDLE;
        endcase
    end

    always_comb begin
        wreq = (dstate == D_WAITACK);
    end

    always_ff @(posedge clk) begin
        if (acc) mem[wbank][adr[NB-1:3]][{adr[2:0], 3'b000} +: 8] <= dw;
    end

    // Drain-side updates come first so a same-cycle reopen of the freed bank wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                st[b]  <= B_FREE;
                tag[b] <= '0;
                for (int i = 0; i < NTFR; i++) mask[b][i] <= '0;
            end
            has      <= '0;
            wb       <= 1'b0;
            db       <= 1'b0;
            beat     <= '0;
            wdata_p1 <= '0;
            wstrb_p1 <= '0;
        end else begin
            if (drain_start) st[db] <= B_DRAIN;
            if (wack && (dstate != D_IDLE)) beat <= beat + 1'b1;
            if (drain_done) begin
                st[db]  <= B_FREE;
                has[db] <= 1'b0;
                for (int i = 0; i < NTFR; i++) mask[db][i] <= '0;
                db <= ~db;
            end
            if (rd_go) begin
                wdata_p1 <= mem[db][rd_idx];
                wstrb_p1 <= mask[db][rd_idx];
            end
            if (acc) begin
                if (!hit) begin
                    if (open_v) st[wb] <= B_CLOSED;
                    st[nb]  <= B_OPEN;
                    tag[nb] <= adr[23:NB];
                end
                mask[wbank][adr[NB-1:3]][adr[2:0]] <= 1'b1;
                has[wbank] <= 1'b1;
                if (close_now) st[wbank] <= B_CLOSED;
            end else if (flush && open_v) begin
                st[wb] <= has[wb] ? B_CLOSED : B_FREE;
            end
            wb <= wb_nxt;
        end
    end

    assign idle  = (st[0] == B_FREE) && (st[1] == B_FREE) && (dstate == D_IDLE);
    assign wadr  = {tag[db], {NB{1'b0}}};
    assign wdata = wdata_p1;
    assign wstrb = wstrb_p1;
endmodule

// File: tb/tb_output_wbuf.sv
// Bench for output_wbuf: table of sparse-write bursts plus fill, stall, ordering
// and reset-mid-burst sequences, with beats checked against an expected-beat queue.
module tb_output_wbuf;
    logic        clk = 1'b0;
    logic        rst, flush, we, wack;
    logic [23:0] adr;
    logic [7:0]  dw;
    logic        rdy, idle, wreq;
    logic [23:0] wadr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;

    always #5 clk = ~clk;

    output_wbuf dut (
        .clk(clk), .rst(rst), .flush(flush), .we(we), .adr(adr), .dw(dw),
        .rdy(rdy), .idle(idle), .wreq(wreq), .wack(wack), .wadr(wadr),
        .wdata(wdata), .wstrb(wstrb)
    );

    typedef struct {
        logic [23:0] wadr;
        logic        first;
        logic [63:0] data;
        logic [7:0]  strb;
    } beat_t;

    typedef struct {
        logic [23:0] a;
        logic [7:0]  d;
        int          fmode;   // 0 separate flush, 1 flush with write, 2 auto-close
        logic [23:0] exp_wadr;
        int          exp_beat;
        logic [7:0]  exp_strb;
        logic [63:0] exp_data;
    } vec_t;

    beat_t sb[$];
    beat_t mon_e;
    int    checks = 0, errors = 0;
    int    wmode = 0;          // 0 wack=1, 1 random wack, 2 wack held by the test
    bit    in_burst = 0;
    int    nbeat = 0;

    function automatic logic [63:0] smask(input logic [7:0] s);
        logic [63:0] m;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{s[k]}};
        return m;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && wack && (wreq || in_burst)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: wadr %h wstrb %h with no beat expected", wadr, wstrb);
            end else begin
                mon_e = sb.pop_front();
                chk("first_beat", {63'b0, !in_burst}, {63'b0, mon_e.first});
                if (!in_burst) begin
                    chk("wadr", wadr, mon_e.wadr);
                    in_burst = 1;
                    nbeat = 0;
                end
                chk("wstrb", wstrb, mon_e.strb);
                chk("wdata", wdata & smask(mon_e.strb), mon_e.data);
                nbeat++;
                if (nbeat == 64) in_burst = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        case (wmode)
            0: wack = 1'b1;
            1: wack = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic write(input logic [23:0] a, input logic [7:0] d, input logic f);
        int n = 0;
        adr = a; dw = d; we = 1'b1; flush = f;
        #1;
        while (!rdy && n < 2000) begin
            step();
            #1;
            n++;
        end
        if (n >= 2000) chk("write_stall_timeout", 0, 1);
        step();
        we = 1'b0; flush = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic push_single(input logic [23:0] wa, input int bt,
                               input logic [7:0] s, input logic [63:0] d);
        beat_t e;
        for (int b = 0; b < 64; b++) begin
            e.wadr  = wa;
            e.first = (b == 0);
            e.strb  = (b == bt) ? s : 8'h00;
            e.data  = (b == bt) ? d : 64'h0;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        #1;
        while (!(idle && sb.size() == 0) && n < 5000) begin
            step();
            #1;
            n++;
        end
        chk({name, "_idle"}, {63'b0, idle}, 1);
        chk({name, "_beats_left"}, sb.size(), 0);
    endtask

    vec_t vecs[5];

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        beat_t e;
        int    n;

        vecs[0] = '{24'h001203, 8'hAB, 0, 24'h001200, 0,  8'h08, 64'h00000000_AB000000};
        vecs[1] = '{24'h000007, 8'h5A, 1, 24'h000000, 0,  8'h80, 64'h5A000000_00000000};
        vecs[2] = '{24'hFFFFF8, 8'hC3, 0, 24'hFFFE00, 63, 8'h01, 64'h00000000_000000C3};
        vecs[3] = '{24'h123456, 8'h7E, 1, 24'h123400, 10, 8'h40, 64'h007E0000_00000000};
        vecs[4] = '{24'h0003FF, 8'h96, 2, 24'h000200, 63, 8'h80, 64'h96000000_00000000};

        rst = 1'b1; flush = 1'b0; we = 1'b0; wack = 1'b0; adr = '0; dw = '0;
        wmode = 2;
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset_rdy", {63'b0, rdy}, 1);
        chk("reset_idle", {63'b0, idle}, 1);
        chk("reset_wreq", {63'b0, wreq}, 0);
        chk("reset_wadr", wadr, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_wstrb", wstrb, 0);

        // Full window fill, auto-close at offset 511
        wmode = 0;
        for (int b = 0; b < 64; b++) begin
            e.wadr = 24'h000000; e.first = (b == 0); e.strb = 8'hFF;
            for (int k = 0; k < 8; k++) e.data[8*k +: 8] = 8'((8*b + k) & 255);
            sb.push_back(e);
        end
        for (int o = 0; o < 512; o++) begin
            write(24'(o), 8'(o & 255), 1'b0);
            if (o == 0) begin
                #1;
                chk("idle_after_first_write", {63'b0, idle}, 0);
            end
        end
        wait_idle("fill");

        // Sparse single-byte windows with random backpressure
        wmode = 1;
        for (int i = 0; i < 5; i++) begin
            push_single(vecs[i].exp_wadr, vecs[i].exp_beat, vecs[i].exp_strb, vecs[i].exp_data);
            case (vecs[i].fmode)
                0: begin write(vecs[i].a, vecs[i].d, 1'b0); pulse_flush(); end
                1: write(vecs[i].a, vecs[i].d, 1'b1);
                default: write(vecs[i].a, vecs[i].d, 1'b0);
            endcase
            wait_idle($sformatf("vec%0d", i));
        end

        // Stall while both banks occupied
        wmode = 2; wack = 1'b0;
        push_single(24'h000000, 0, 8'h01, 64'h33);
        push_single(24'h000200, 0, 8'h01, 64'h44);
        write(24'h000000, 8'h33, 1'b0);
        write(24'h000200, 8'h44, 1'b0);
        adr = 24'h000400; dw = 8'h55; we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_rdy_low", {63'b0, rdy}, 0);
            step();
        end
        #1;
        chk("stall_wreq_high", {63'b0, wreq}, 1);
        wack = 1'b1;
        for (int j = 0; j < 64; j++) begin
            #1;
            chk($sformatf("stall_rdy_wack%0d", j + 1), {63'b0, rdy}, (j == 63) ? 1 : 0);
            step();
        end
        we = 1'b0;
        wmode = 0;
        push_single(24'h000400, 0, 8'h01, 64'h55);
        pulse_flush();
        wait_idle("stall");

        // Ordering: rewrite of a draining window lands in a later burst
        wmode = 1;
        push_single(24'h000000, 2, 8'h01, 64'h11);
        push_single(24'h000600, 0, 8'h01, 64'h99);
        push_single(24'h000000, 2, 8'h01, 64'h22);
        write(24'h000010, 8'h11, 1'b0);
        write(24'h000600, 8'h99, 1'b0);
        write(24'h000010, 8'h22, 1'b0);
        pulse_flush();
        wait_idle("ordering");

        // Reset after 10 wacks abandons the burst
        wmode = 2; wack = 1'b0;
        push_single(24'h000800, 0, 8'h01, 64'h12);
        write(24'h000800, 8'h12, 1'b1);
        n = 0;
        #1;
        while (!wreq && n < 100) begin step(); #1; n++; end
        chk("rstmid_wreq_seen", {63'b0, wreq}, 1);
        wack = 1'b1;
        repeat (10) step();
        rst = 1'b1; wack = 1'b0;
        step();
        #1;
        chk("rstmid_wreq", {63'b0, wreq}, 0);
        chk("rstmid_rdy", {63'b0, rdy}, 1);
        chk("rstmid_idle", {63'b0, idle}, 1);
        chk("rstmid_beats_consumed", sb.size(), 54);
        sb.delete();
        in_burst = 0;
        rst = 1'b0;
        wack = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            #1;
            if (wreq) n++;
        end
        chk("rstmid_no_burst", n, 0);
        chk("rstmid_idle_hold", {63'b0, idle}, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
